rsa_stream_wrapper: RTL and testbench
=====================================

Name: rsa_stream_wrapper

Overview:
Byte-stream front end for Rsa256Core: it sits between the UART byte interface and the core.
- Assembles the 32-byte modulus n, then the 32-byte exponent d, then repeated 32-byte ciphertext blocks a.
- Pulses the core start, waits for core finish, and streams the 31-byte plaintext (result bits 247:0) back out MSB-first.
- Key (n, d) is retained across blocks until reset.

Parameters:
IN_BYTES, 32, bytes per received operand (n, d, a), MSB-first
OUT_BYTES, 31, bytes transmitted per result, taken from result[8*OUT_BYTES-1:0], MSB-first

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_rx_data  input  8  received byte
i_rx_valid  input  1  rx byte available
o_rx_ready  output  1  wrapper accepts byte; transfer when valid&&ready
o_tx_data  output  8  byte to transmit
o_tx_valid  output  1  tx byte available
i_tx_ready  input  1  sink accepts byte; transfer when valid&&ready
o_core_start  output  1  one-cycle start pulse to core i_start
o_core_a  output  256  ciphertext to core i_a
o_core_d  output  256  exponent to core i_d
o_core_n  output  256  modulus to core i_n
i_core_result  input  256  core o_a_pow_d
i_core_finished  input  1  core o_finished
o_busy  output  1  high in S_START/S_WAIT/S_SEND

Behaviour:
- Reset (async, active-low):
  - State S_GET_N; byte counter 0.
  - n/d/a/tx shift registers all 0.
  - All outputs 0 during reset.
  - o_rx_ready goes 1 on the first clock edge after reset release.
- States:
  - S_GET_N, S_GET_D, S_GET_A: o_rx_ready=1.
    - Each accepted byte: reg <= {reg[247:0], i_rx_data}; cnt++.
    - When cnt==IN_BYTES-1 and a byte is accepted: cnt<=0, advance GET_N->GET_D->GET_A->S_START.
  - S_START: o_core_start=1 for exactly one cycle -> S_WAIT.
  - S_WAIT: when i_core_finished=1, latch i_core_result[8*OUT_BYTES-1:0] into the tx shift register, cnt<=0 -> S_SEND.
  - S_SEND: o_tx_valid=1; o_tx_data = tx_reg top byte.
    - On valid&&ready: shift left 8, cnt++.
    - On the transfer with cnt==OUT_BYTES-1: -> S_GET_A (key kept).
- Latency:
  - Last a byte accepted at edge k -> o_core_start high in cycle k+1.
  - Finish sampled at edge m -> o_tx_valid high in cycle m+1 with result byte 30.
- o_core_a/d/n are registers and hold stable from load until overwritten; o_core_a is unchanged while busy.
- rx_valid outside GET states: not accepted, since o_rx_ready=0. Bytes stay pending at the source.
- Gaps in rx_valid or tx_ready: no effect except stall.
  - While stalled, o_tx_data and o_tx_valid are stable.
  - No byte is duplicated or dropped.
- i_core_finished outside S_WAIT: ignored.
- Finish in the same cycle as entering S_WAIT: accepted. The core cannot finish earlier than that; no special case.
- result[255:248] is discarded by protocol; plaintext blocks are 31 bytes.
- Reset mid-operation (any state): immediate return to S_GET_N. The key must be resent. A later core finish is ignored until S_WAIT.
- Counter width: $clog2(IN_BYTES); no wrap beyond the terminal count.

Decomposition:
- Package rsa_pkg holds:
  - state enum (S_GET_N, S_GET_D, S_GET_A, S_START, S_WAIT, S_SEND)
  - RSA_BITS=256
  - byte constants IN_BYTES/OUT_BYTES defaults
- One natural sub-module: byte_shift_reg (parallel-load / serial-in / serial-out 8-bit shifter with enable). Instantiated for the rx operand assembly and the tx result.
- FSM and counter stay in the top.

Test Plan:
- Reset: hold i_rst_n=0 for 2 cycles with rx_valid=1 -> all outputs 0. o_rx_ready=1 one edge after release. No byte is consumed during reset.
- Key+block load, core stub:
  - Stimulus: send n=CA3586E7…029CF831, d=B6ACE0B1…BCF46BD9, a=31×00,01 back-to-back.
  - Required: o_core_n and o_core_d equal those values; o_core_a=…0001; exactly one o_core_start pulse, one cycle after the 96th byte.
- Result stream:
  - Stimulus: stub asserts finished with result = 0xFF followed by bytes 01..1F.
  - Required: tx emits exactly 01,02,…,1F (31 bytes; 0xFF dropped). Then o_rx_ready=1 in S_GET_A, and a second block starts after only 32 bytes (key retained).
- Back-pressure:
  - Stimulus: drop i_tx_ready for 5 cycles after byte 10, and insert random rx_valid bubbles.
  - Required: identical byte sequence; o_tx_data stable during the stall; start pulse count unchanged.
- Reset mid S_WAIT:
  - Stimulus: assert i_rst_n=0, then pulse finished afterwards.
  - Required: no tx activity; state expects n again; o_core_start stays 0.
- Real Rsa256Core integrated:
  - Stimulus: stream 5 blocks from golden/enc1.bin.
  - Required: tx bytes match golden/dec1.txt (31 bytes each). Each block completes within the core's cycle budget.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA byte-stream front end.
package rsa_pkg;

   localparam int RSA_BITS      = 256;
   localparam int IN_BYTES_DEF  = 32;
   localparam int OUT_BYTES_DEF = 31;

   typedef enum logic [2:0] {
      S_GET_N,
      S_GET_D,
      S_GET_A,
      S_START,
      S_WAIT,
      S_SEND
   } state_t;

endpackage

// File: rtl/byte_shift_reg.sv
// Byte-wide shifter: parallel load, serial byte in at the bottom, serial byte
// out from the top. Load has priority over shift.
module byte_shift_reg #(
   parameter int NBYTES = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [8*NBYTES-1:0]   load_data,
   input  logic                  shift_en,
   input  logic [7:0]            serial_in,
   output logic [8*NBYTES-1:0]   q,
   output logic [7:0]            serial_out
);

   // Register contents: cleared on reset, then loaded or shifted left one byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= load_data;
      end else if (shift_en) begin
         q <= {q[8*NBYTES-9:0], serial_in};
      end
   end

   assign serial_out = q[8*NBYTES-1 -: 8];

endmodule

// File: rtl/rsa_stream_wrapper.sv
// Byte-stream front end for the RSA-256 core: assembles n, d and repeated
// ciphertext blocks from rx bytes, kicks the core, and streams the 31-byte
// plaintext back out MSB-first. The key stays loaded until reset.
module rsa_stream_wrapper
   import rsa_pkg::*;
#(
   parameter int IN_BYTES  = IN_BYTES_DEF,
   parameter int OUT_BYTES = OUT_BYTES_DEF
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [7:0]          i_rx_data,
   input  logic                i_rx_valid,
   output logic                o_rx_ready,
   output logic [7:0]          o_tx_data,
   output logic                o_tx_valid,
   input  logic                i_tx_ready,
   output logic                o_core_start,
   output logic [RSA_BITS-1:0] o_core_a,
   output logic [RSA_BITS-1:0] o_core_d,
   output logic [RSA_BITS-1:0] o_core_n,
   input  logic [RSA_BITS-1:0] i_core_result,
   input  logic                i_core_finished,
   output logic                o_busy
);

   localparam int CW = $clog2(IN_BYTES);
   localparam logic [CW-1:0] IN_LAST  = CW'(IN_BYTES - 1);
   localparam logic [CW-1:0] OUT_LAST = CW'(OUT_BYTES - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          rdy_en;
   logic          n_en, d_en, a_en;
   logic          tx_load, tx_shift;
   logic [7:0]    n_top, d_top, a_top;
   logic [8*OUT_BYTES-1:0] tx_q;
   logic          unused_ok;

   // State, byte counter, and the ready enable that keeps o_rx_ready low
   // until the first edge after reset release.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= S_GET_N;
         cnt    <= '0;
         rdy_en <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         rdy_en <= 1'b1;
      end
   end

   // Next-state, counter and handshake decode.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      n_en         = 1'b0;
      d_en         = 1'b0;
      a_en         = 1'b0;
      tx_load      = 1'b0;
      tx_shift     = 1'b0;
      o_rx_ready   = 1'b0;
      o_tx_valid   = 1'b0;
      o_core_start = 1'b0;
      o_busy       = 1'b0;
      case (state)
         S_GET_N, S_GET_D, S_GET_A: begin
            o_rx_ready = rdy_en;
            if (rdy_en && i_rx_valid) begin
               n_en = (state == S_GET_N);
               d_en = (state == S_GET_D);
               a_en = (state == S_GET_A);
               if (cnt == IN_LAST) begin
                  cnt_nxt = '0;
                  case (state)
                     S_GET_N: state_nxt = S_GET_D;
                     S_GET_D: state_nxt = S_GET_A;
                     default: state_nxt = S_START;
                  endcase
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         S_START: begin
            o_core_start = 1'b1;
            o_busy       = 1'b1;
            state_nxt    = S_WAIT;
         end
         S_WAIT: begin
            o_busy = 1'b1;
            if (i_core_finished) begin
               tx_load   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = S_SEND;
            end
         end
         S_SEND: begin
            o_busy     = 1'b1;
            o_tx_valid = 1'b1;
            if (i_tx_ready) begin
               tx_shift = 1'b1;
               if (cnt == OUT_LAST) begin
                  cnt_nxt   = '0;
                  state_nxt = S_GET_A;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         default: state_nxt = S_GET_N;
      endcase
   end

   byte_shift_reg #(.NBYTES(IN_BYTES)) u_n_reg (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .load       (1'b0),
      .load_data  ('0),
      .shift_en   (n_en),
      .serial_in  (i_rx_data),
      .q          (o_core_n),
      .serial_out (n_top)
   );

   byte_shift_reg #(.NBYTES(IN_BYTES)) u_d_reg (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .load       (1'b0),
      .load_data  ('0),
      .shift_en   (d_en),
      .serial_in  (i_rx_data),
      .q          (o_core_d),
      .serial_out (d_top)
   );

   byte_shift_reg #(.NBYTES(IN_BYTES)) u_a_reg (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .load       (1'b0),
      .load_data  ('0),
      .shift_en   (a_en),
      .serial_in  (i_rx_data),
      .q          (o_core_a),
      .serial_out (a_top)
   );

   // Result byte 255:248 is dropped by protocol; only the low OUT_BYTES go out.
   byte_shift_reg #(.NBYTES(OUT_BYTES)) u_tx_reg (
      .clk        (i_clk),
      .rst_n      (i_rst_n),
      .load       (tx_load),
      .load_data  (i_core_result[8*OUT_BYTES-1:0]),
      .shift_en   (tx_shift),
      .serial_in  (8'h00),
      .q          (tx_q),
      .serial_out (o_tx_data)
   );

   assign unused_ok = ^{i_core_result[RSA_BITS-1:8*OUT_BYTES], n_top, d_top, a_top, tx_q};

endmodule

// File: tb/tb_rsa_stream_wrapper.sv
module tb_rsa_stream_wrapper;

   logic         i_clk = 1'b0;
   logic         i_rst_n = 1'b1;
   logic [7:0]   i_rx_data = 8'h00;
   logic         i_rx_valid = 1'b0;
   logic         o_rx_ready;
   logic [7:0]   o_tx_data;
   logic         o_tx_valid;
   logic         i_tx_ready = 1'b0;
   logic         o_core_start;
   logic [255:0] o_core_a, o_core_d, o_core_n;
   logic [255:0] i_core_result = '0;
   logic         i_core_finished = 1'b0;
   logic         o_busy;

   int total = 0;
   int bad = 0;
   int start_cnt = 0;
   logic [7:0] sb[$];

   typedef struct {
      logic [255:0] a;
      logic [255:0] res;
      int           stall_after;
      bit           bubbles;
      int           wait_cyc;
   } vec_t;

   vec_t vecs[4];

   localparam logic [255:0] KEY_N  = 256'hCA3586E7_1B4D92F0_5E6A7C38_D19E2B47_A0C4F15E_38B7D26A_94E1C05B_029CF831;
   localparam logic [255:0] KEY_D  = 256'hB6ACE0B1_7F29D34E_0A5C81B6_E3F47D92_55C1A80E_9B3D6F27_C84E12A9_BCF46BD9;
   localparam logic [255:0] KEY_N2 = 256'h01234567_89ABCDEF_FEDCBA98_76543210_0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
   localparam logic [255:0] KEY_D2 = 256'h10000000_00000000_00000000_00000000_00000000_00000000_00000000_00010001;

   rsa_stream_wrapper dut (
      .i_clk           (i_clk),
      .i_rst_n         (i_rst_n),
      .i_rx_data       (i_rx_data),
      .i_rx_valid      (i_rx_valid),
      .o_rx_ready      (o_rx_ready),
      .o_tx_data       (o_tx_data),
      .o_tx_valid      (o_tx_valid),
      .i_tx_ready      (i_tx_ready),
      .o_core_start    (o_core_start),
      .o_core_a        (o_core_a),
      .o_core_d        (o_core_d),
      .o_core_n        (o_core_n),
      .i_core_result   (i_core_result),
      .i_core_finished (i_core_finished),
      .o_busy          (o_busy)
   );

   always #5 i_clk = ~i_clk;

   // Count start pulses seen by the core.
   always @(posedge i_clk) begin
      if (o_core_start) start_cnt <= start_cnt + 1;
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      logic r;
      int   guard;
      i_rx_valid = 1'b0;
      repeat (gap) tick();
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      guard = 0;
      do begin
         r = o_rx_ready;
         tick();
         guard++;
      end while (!r && guard < 50);
      i_rx_valid = 1'b0;
      if (!r) chk("rx_accept_timeout", {255'd0, r}, 256'd1);
   endtask

   task automatic send_operand(input logic [255:0] v, input bit bubbles);
      for (int i = 0; i < 32; i++) begin
         send_byte(v[255-8*i -: 8], bubbles ? int'($urandom_range(0, 2)) : 0);
      end
   endtask

   task automatic run_block(input vec_t v);
      int         starts_before;
      int         got, guard, stall_left;
      bit         rdy, have_prev;
      logic [7:0] prev_data, exp;
      // A stray finish while idle must be ignored.
      i_core_finished = 1'b1;
      tick();
      i_core_finished = 1'b0;
      chk("finish_ignored_valid", o_tx_valid, 1'b0);
      chk("finish_ignored_busy", o_busy, 1'b0);
      starts_before = start_cnt;
      send_operand(v.a, v.bubbles);
      chk("start_pulse", o_core_start, 1'b1);
      chk("core_a", o_core_a, v.a);
      tick();
      chk("start_one_cycle", o_core_start, 1'b0);
      chk("start_count", start_cnt, starts_before + 1);
      chk("busy_wait", o_busy, 1'b1);
      for (int i = 0; i < v.wait_cyc; i++) begin
         chk("wait_no_tx", o_tx_valid, 1'b0);
         tick();
      end
      for (int i = 30; i >= 0; i--) sb.push_back(v.res[8*i +: 8]);
      i_core_result   = v.res;
      i_core_finished = 1'b1;
      tick();
      i_core_finished = 1'b0;
      chk("tx_latency", o_tx_valid, 1'b1);
      got = 0; guard = 0; stall_left = 5; have_prev = 1'b0; prev_data = 8'h00;
      while (got < 31 && guard < 400) begin
         rdy = 1'b1;
         if (v.stall_after >= 0 && got == v.stall_after && stall_left > 0) begin
            rdy = 1'b0;
            stall_left--;
         end else if (v.bubbles && $urandom_range(0, 3) == 0) begin
            rdy = 1'b0;
         end
         i_tx_ready = rdy;
         if (have_prev) begin
            chk("tx_hold_data", o_tx_data, prev_data);
            chk("tx_hold_valid", o_tx_valid, 1'b1);
         end
         have_prev = 1'b0;
         if (o_tx_valid) begin
            if (rdy) begin
               exp = sb.pop_front();
               chk("tx_byte", o_tx_data, exp);
               got++;
            end else begin
               have_prev = 1'b1;
               prev_data = o_tx_data;
            end
         end
         tick();
         guard++;
      end
      i_tx_ready = 1'b0;
      chk("tx_byte_count", got, 31);
      chk("tx_done_valid", o_tx_valid, 1'b0);
      chk("ready_get_a", o_rx_ready, 1'b1);
      chk("idle_busy", o_busy, 1'b0);
      chk("core_a_hold", o_core_a, v.a);
      chk("start_count_after", start_cnt, starts_before + 1);
      chk("sb_empty", sb.size(), 0);
      sb.delete();
   endtask

   initial begin
      int starts_before;
      vecs[0] = '{a: 256'd1,
                  res: 256'hFF010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F,
                  stall_after: -1, bubbles: 1'b0, wait_cyc: 3};
      vecs[1] = '{a: 256'h1F2E3D4C_5B6A7988_97A6B5C4_D3E2F100_11223344_55667788_99AABBCC_DDEEFF01,
                  res: 256'h5AC3D2E1_F0112233_44556677_8899AABB_CCDDEEFF_00102030_40506070_8090A0B0,
                  stall_after: 10, bubbles: 1'b1, wait_cyc: 7};
      vecs[2] = '{a: '1, res: '1, stall_after: -1, bubbles: 1'b0, wait_cyc: 0};
      vecs[3] = '{a: 256'd0,
                  res: 256'h7E8000FF_0180FE7F_00000000_FFFFFFFF_A5A5A5A5_5A5A5A5A_01020304_F0E0D0C0,
                  stall_after: 0, bubbles: 1'b1, wait_cyc: 2};

      // Reset with a byte pending: nothing may be consumed.
      i_rst_n    = 1'b0;
      i_rx_valid = 1'b1;
      i_rx_data  = 8'h55;
      repeat (2) tick();
      chk("rst_rx_ready", o_rx_ready, 1'b0);
      chk("rst_tx_valid", o_tx_valid, 1'b0);
      chk("rst_tx_data", o_tx_data, 8'h00);
      chk("rst_start", o_core_start, 1'b0);
      chk("rst_busy", o_busy, 1'b0);
      chk("rst_core_n", o_core_n, 256'd0);
      chk("rst_core_d", o_core_d, 256'd0);
      chk("rst_core_a", o_core_a, 256'd0);
      i_rst_n = 1'b1;
      #1;
      chk("ready_before_edge", o_rx_ready, 1'b0);
      tick();
      i_rx_valid = 1'b0;
      chk("ready_after_release", o_rx_ready, 1'b1);

      send_operand(KEY_N, 1'b0);
      send_operand(KEY_D, 1'b0);
      chk("core_n", o_core_n, KEY_N);
      chk("core_d", o_core_d, KEY_D);
      chk("ready_first_a", o_rx_ready, 1'b1);

      for (int i = 0; i < 4; i++) begin
         run_block(vecs[i]);
         chk("key_n_kept", o_core_n, KEY_N);
         chk("key_d_kept", o_core_d, KEY_D);
      end

      // Reset while the core is running; a late finish must do nothing.
      send_operand(256'h1234, 1'b0);
      chk("mid_start", o_core_start, 1'b1);
      tick();
      chk("mid_busy", o_busy, 1'b1);
      starts_before = start_cnt;
      i_rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", o_busy, 1'b0);
      chk("mid_rst_core_n", o_core_n, 256'd0);
      chk("mid_rst_core_a", o_core_a, 256'd0);
      tick();
      tick();
      i_rst_n = 1'b1;
      tick();
      i_core_result   = '1;
      i_core_finished = 1'b1;
      tick();
      i_core_finished = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("late_finish_tx", o_tx_valid, 1'b0);
         chk("late_finish_start", o_core_start, 1'b0);
         chk("late_finish_busy", o_busy, 1'b0);
         tick();
      end
      chk("late_finish_starts", start_cnt, starts_before);

      // Fresh key required: bytes now land in n again.
      send_operand(KEY_N2, 1'b1);
      chk("new_n_before_d", o_core_d, 256'd0);
      send_operand(KEY_D2, 1'b0);
      chk("new_core_n", o_core_n, KEY_N2);
      chk("new_core_d", o_core_d, KEY_D2);
      run_block(vecs[1]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
